// File: rtl/systolic_matmul_nxn.sv
// Output-stationary NxN signed systolic matrix multiply, C = A*B or A*B^T, each result divided by SCALE.
// Latency: done pulses 3N cycles after the start edge. No backpressure: start is ignored while busy, never queued.
module systolic_matmul_nxn #(
    parameter int N     = 3,
    parameter int DW    = 21,
    parameter int ACCW  = 2*DW + $clog2(N) + 1,
    parameter int SCALE = 100
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_trans_b,
    input  logic [N*N*DW-1:0]     i_a_flat,
    input  logic [N*N*DW-1:0]     i_b_flat,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [N*N*ACCW-1:0]   o_c_flat
);
    localparam int SKL  = 2*N - 1;
    localparam int LAST = 3*N - 3;
    localparam int CW   = $clog2(3*N - 1);
    localparam logic signed [ACCW-1:0] SCALE_S = ACCW'(SCALE);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_SCALE, S_DONE} state_t;

    state_t                    r_state, w_next;
    logic [CW-1:0]             r_cnt;
    logic [N*N*DW-1:0]         r_a_cap, r_b_cap;
    logic                      r_tb;
    logic [N*N*ACCW-1:0]       r_c;
    logic signed [DW-1:0]      r_rsk [N][SKL];
    logic signed [DW-1:0]      r_csk [N][SKL];
    logic signed [DW-1:0]      r_ap  [N][N-1];
    logic signed [DW-1:0]      r_bp  [N-1][N];
    logic signed [ACCW-1:0]    r_acc [N][N];

    logic signed [DW-1:0]      w_a [N][N];
    logic signed [DW-1:0]      w_b [N][N];
    logic signed [DW-1:0]      w_rsk_ld [N][SKL];
    logic signed [DW-1:0]      w_csk_ld [N][SKL];
    logic signed [DW-1:0]      w_ain [N][N];
    logic signed [DW-1:0]      w_bin [N][N];
    logic signed [2*DW-1:0]    w_prod [N][N];
    logic signed [ACCW-1:0]    w_q [N][N];
    logic                      w_accept;

    assign w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign o_busy   = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_SCALE);
    assign o_done   = (r_state == S_DONE);
    assign o_c_flat = r_c;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_RUN) ? r_cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_LOAD;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   if (r_cnt == CW'(LAST)) w_next = S_SCALE;
            S_SCALE: w_next = S_DONE;
            S_DONE:  w_next = i_start ? S_LOAD : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Row i / column j of the skew banks holds i (j) leading zeros, then the operand stream.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                w_a[r][c] = r_a_cap[(r*N+c)*DW +: DW];
                w_b[r][c] = r_b_cap[(r*N+c)*DW +: DW];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < SKL; p++) begin
                w_rsk_ld[i][p] = '0;
                w_csk_ld[i][p] = '0;
            end
            for (int k = 0; k < N; k++) begin
                w_rsk_ld[i][i+k] = w_a[i][k];
                w_csk_ld[i][i+k] = r_tb ? w_b[i][k] : w_b[k][i];
            end
        end
        for (int i = 0; i < N; i++) begin
            w_ain[i][0] = r_rsk[i][0];
            for (int j = 1; j < N; j++) w_ain[i][j] = r_ap[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            w_bin[0][j] = r_csk[j][0];
            for (int i = 1; i < N; i++) w_bin[i][j] = r_bp[i-1][j];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_prod[i][j] = w_ain[i][j] * w_bin[i][j];
                w_q[i][j]    = (SCALE == 1) ? r_acc[i][j] : r_acc[i][j] / SCALE_S;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_cap <= '0;
            r_b_cap <= '0;
            r_tb    <= 1'b0;
            r_c     <= '0;
            for (int i = 0; i < N; i++) begin
                for (int p = 0; p < SKL; p++) begin
                    r_rsk[i][p] <= '0;
                    r_csk[i][p] <= '0;
                end
                for (int j = 0; j < N; j++) r_acc[i][j] <= '0;
                for (int j = 0; j < N-1; j++) begin
                    r_ap[i][j] <= '0;
                    r_bp[j][i] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                r_a_cap <= i_a_flat;
                r_b_cap <= i_b_flat;
                r_tb    <= i_trans_b;
            end
            case (r_state)
                S_LOAD: begin
                    for (int i = 0; i < N; i++) begin
                        for (int p = 0; p < SKL; p++) begin
                            r_rsk[i][p] <= w_rsk_ld[i][p];
                            r_csk[i][p] <= w_csk_ld[i][p];
                        end
                        for (int j = 0; j < N; j++) r_acc[i][j] <= '0;
                        for (int j = 0; j < N-1; j++) begin
                            r_ap[i][j] <= '0;
                            r_bp[j][i] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < N; i++) begin
                        for (int p = 0; p < SKL-1; p++) begin
                            r_rsk[i][p] <= r_rsk[i][p+1];
                            r_csk[i][p] <= r_csk[i][p+1];
                        end
                        r_rsk[i][SKL-1] <= '0;
                        r_csk[i][SKL-1] <= '0;
                        for (int j = 0; j < N; j++)
                            r_acc[i][j] <= r_acc[i][j] +
                                {{(ACCW-2*DW){w_prod[i][j][2*DW-1]}}, w_prod[i][j]};
                        for (int j = 0; j < N-1; j++) begin
                            r_ap[i][j] <= w_ain[i][j];
                            r_bp[j][i] <= w_bin[j][i];
                        end
                    end
                end
                S_SCALE: begin
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++)
                            r_c[(i*N+j)*ACCW +: ACCW] <= w_q[i][j];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Directed and random checks of systolic_matmul_nxn at N=3 (SCALE 1 and 100) and N=4 (DW=16).
module tb_systolic_matmul_nxn;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic s1_start = 0, s1_tb = 0, s1_busy, s1_done;
    logic [188:0] s1_a = '0, s1_b = '0;
    logic [404:0] s1_c;
    logic s2_start = 0, s2_tb = 0, s2_busy, s2_done;
    logic [188:0] s2_a = '0, s2_b = '0;
    logic [404:0] s2_c;
    logic s4_start = 0, s4_tb = 0, s4_busy, s4_done;
    logic [255:0] s4_a = '0, s4_b = '0;
    logic [559:0] s4_c;

    systolic_matmul_nxn #(.N(3), .DW(21), .SCALE(1)) u_s1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s1_start), .i_trans_b(s1_tb),
        .i_a_flat(s1_a), .i_b_flat(s1_b), .o_busy(s1_busy), .o_done(s1_done), .o_c_flat(s1_c));
    systolic_matmul_nxn #(.N(3), .DW(21), .SCALE(100)) u_s2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s2_start), .i_trans_b(s2_tb),
        .i_a_flat(s2_a), .i_b_flat(s2_b), .o_busy(s2_busy), .o_done(s2_done), .o_c_flat(s2_c));
    systolic_matmul_nxn #(.N(4), .DW(16), .SCALE(1)) u_s4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s4_start), .i_trans_b(s4_tb),
        .i_a_flat(s4_a), .i_b_flat(s4_b), .o_busy(s4_busy), .o_done(s4_done), .o_c_flat(s4_c));

    function automatic logic [188:0] pk3(input int m[9]);
        logic [188:0] v = '0;
        for (int k = 0; k < 9; k++) v[k*21 +: 21] = m[k][20:0];
        return v;
    endfunction

    function automatic logic [404:0] ck3(input longint m[9]);
        logic [404:0] v = '0;
        for (int k = 0; k < 9; k++) v[k*45 +: 45] = m[k][44:0];
        return v;
    endfunction

    // Pulses start on one instance and records busy/done for cycles 1..15 after the sampling edge.
    task automatic run_op(input int which, output logic [15:1] bmask, output logic [15:1] dmask);
        bmask = '0;
        dmask = '0;
        @(negedge clk);
        case (which)
            1: s1_start = 1;
            2: s2_start = 1;
            default: s4_start = 1;
        endcase
        @(negedge clk);
        s1_start = 0; s2_start = 0; s4_start = 0;
        for (int c = 1; c <= 15; c++) begin
            bmask[c] = (which == 1) ? s1_busy : (which == 2) ? s2_busy : s4_busy;
            dmask[c] = (which == 1) ? s1_done : (which == 2) ? s2_done : s4_done;
            if (c < 15) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        if (s1_busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", s1_busy); n_mis++; end
        n_cmp++;
        if (s1_done !== 1'b0) begin $display("FAIL reset_done got %b want 0", s1_done); n_mis++; end
        n_cmp++;
        if (s1_c !== '0) begin $display("FAIL reset_c got %h want 0", s1_c); n_mis++; end
        n_cmp++;
        if (s4_c !== '0 || s4_busy !== 1'b0) begin $display("FAIL reset_s4 got c=%h busy=%b want 0", s4_c, s4_busy); n_mis++; end
        n_cmp++;
        rst_n = 1;
    endtask

    task automatic test_identity();
        logic [15:1] bm, dm;
        logic [404:0] exp_c;
        s1_a = pk3('{1,0,0, 0,1,0, 0,0,1});
        s1_b = pk3('{1,2,3, 4,5,6, 7,8,9});
        s1_tb = 0;
        exp_c = ck3('{1,2,3, 4,5,6, 7,8,9});
        run_op(1, bm, dm);
        if (bm !== 15'h01FF) begin $display("FAIL ident_busy got %h want 01ff", bm); n_mis++; end
        n_cmp++;
        if (dm !== 15'h0200) begin $display("FAIL ident_done got %h want 0200", dm); n_mis++; end
        n_cmp++;
        if (s1_c !== exp_c) begin $display("FAIL ident_c got %h want %h", s1_c, exp_c); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_scale();
        logic [15:1] bm, dm;
        logic [404:0] exp_c;
        s2_a = pk3('{100,0,0, 0,200,0, 0,0,-300});
        s2_b = pk3('{50,50,50, 50,50,50, 50,50,50});
        exp_c = ck3('{50,50,50, 100,100,100, -150,-150,-150});
        run_op(2, bm, dm);
        if (dm !== 15'h0200) begin $display("FAIL scale_done got %h want 0200", dm); n_mis++; end
        n_cmp++;
        if (s2_c !== exp_c) begin $display("FAIL scale_c got %h want %h", s2_c, exp_c); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_truncation();
        logic [15:1] bm, dm;
        logic [404:0] exp_c;
        s2_a = pk3('{-3,0,0, 0,1,0, 0,0,1});
        s2_b = pk3('{50,0,0, 0,1,0, 0,0,1});
        exp_c = ck3('{-1,0,0, 0,0,0, 0,0,0});
        run_op(2, bm, dm);
        if (s2_c[0 +: 45] !== exp_c[0 +: 45]) begin $display("FAIL trunc_c00 got %h want %h", s2_c[0 +: 45], exp_c[0 +: 45]); n_mis++; end
        n_cmp++;
        if (s2_c[180 +: 45] !== exp_c[180 +: 45]) begin $display("FAIL trunc_c11 got %h want 0", s2_c[180 +: 45]); n_mis++; end
        n_cmp++;
        if (s2_c !== exp_c) begin $display("FAIL trunc_all got %h want %h", s2_c, exp_c); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_transpose();
        int dcyc = -1;
        logic [404:0] exp_c = ck3('{1,4,7, 2,5,8, 3,6,9});
        s1_a = pk3('{1,0,0, 0,1,0, 0,0,1});
        s1_b = pk3('{1,2,3, 4,5,6, 7,8,9});
        s1_tb = 1;
        @(negedge clk) s1_start = 1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) s1_start = 0;
            if (c == 2) begin s1_b = '0; s1_tb = 0; end
            if (s1_done && dcyc < 0) dcyc = c;
        end
        if (dcyc !== 10) begin $display("FAIL trans_done_cycle got %0d want 10", dcyc); n_mis++; end
        n_cmp++;
        if (s1_c !== exp_c) begin $display("FAIL trans_c got %h want %h", s1_c, exp_c); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_ignore_start();
        int ndone = 0, first = -1;
        logic [404:0] exp_c = ck3('{2,4,6, 8,10,12, 14,16,18});
        s1_a = pk3('{2,0,0, 0,2,0, 0,0,2});
        s1_b = pk3('{1,2,3, 4,5,6, 7,8,9});
        @(negedge clk) s1_start = 1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) s1_start = 0;
            if (c == 3) s1_start = 1;
            if (c == 4) s1_start = 0;
            if (s1_done) begin ndone++; if (first < 0) first = c; end
        end
        if (ndone !== 1) begin $display("FAIL ignore_ndone got %0d want 1", ndone); n_mis++; end
        n_cmp++;
        if (first !== 10) begin $display("FAIL ignore_done_cycle got %0d want 10", first); n_mis++; end
        n_cmp++;
        if (s1_c !== exp_c) begin $display("FAIL ignore_c got %h want %h", s1_c, exp_c); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic d1 = 0, d2 = 0, stable = 1, extra = 0;
        logic [404:0] r1 = '0;
        logic [404:0] e1 = ck3('{1,2,3, 4,5,6, 7,8,9});
        logic [404:0] e2 = ck3('{9,8,7, 6,5,4, 3,2,1});
        s1_a = pk3('{1,0,0, 0,1,0, 0,0,1});
        s1_b = pk3('{1,2,3, 4,5,6, 7,8,9});
        @(negedge clk) s1_start = 1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) s1_start = 0;
            if (c == 10) begin
                d1 = s1_done; r1 = s1_c;
                s1_b = pk3('{9,8,7, 6,5,4, 3,2,1});
                s1_start = 1;
            end
            if (c == 11) s1_start = 0;
            if (c >= 11 && c <= 19) begin
                if (s1_c !== r1) stable = 0;
                if (s1_done) extra = 1;
            end
            if (c == 20) d2 = s1_done;
        end
        if (d1 !== 1'b1 || r1 !== e1) begin $display("FAIL b2b_first got done=%b c=%h want 1 %h", d1, r1, e1); n_mis++; end
        n_cmp++;
        if (stable !== 1'b1 || extra !== 1'b0) begin $display("FAIL b2b_hold got stable=%b extra=%b want 1 0", stable, extra); n_mis++; end
        n_cmp++;
        if (d2 !== 1'b1) begin $display("FAIL b2b_second_done got %b want 1", d2); n_mis++; end
        n_cmp++;
        if (s1_c !== e2) begin $display("FAIL b2b_second_c got %h want %h", s1_c, e2); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_reset_mid_run();
        int ndone = 0;
        logic [15:1] bm, dm;
        logic [404:0] exp_c = ck3('{30,36,42, 66,81,96, 102,126,150});
        s1_a = pk3('{1,2,3, 4,5,6, 7,8,9});
        s1_b = pk3('{1,2,3, 4,5,6, 7,8,9});
        @(negedge clk) s1_start = 1;
        @(negedge clk) s1_start = 0;
        repeat (4) @(negedge clk);
        rst_n = 0;
        #1;
        if (s1_busy !== 1'b0 || s1_done !== 1'b0) begin $display("FAIL midrst_ctrl got busy=%b done=%b want 0 0", s1_busy, s1_done); n_mis++; end
        n_cmp++;
        if (s1_c !== '0) begin $display("FAIL midrst_c got %h want 0", s1_c); n_mis++; end
        n_cmp++;
        @(negedge clk) rst_n = 1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (s1_done) ndone++;
        end
        if (ndone !== 0) begin $display("FAIL midrst_no_done got %0d want 0", ndone); n_mis++; end
        n_cmp++;
        run_op(1, bm, dm);
        if (dm !== 15'h0200 || s1_c !== exp_c) begin $display("FAIL midrst_next got done=%h c=%h want 0200 %h", dm, s1_c, exp_c); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_random_n4();
        int am[16], bmat[16];
        logic [15:1] bm, dm;
        logic [559:0] exp_c;
        logic signed [15:0] t;
        longint s;
        for (int run = 0; run < 200; run++) begin
            for (int k = 0; k < 16; k++) begin
                if (run == 0) begin am[k] = -32768; bmat[k] = -32768; end
                else if (run == 1) begin am[k] = -32768; bmat[k] = 32767; end
                else begin
                    t = 16'($urandom); am[k] = t;
                    t = 16'($urandom); bmat[k] = t;
                end
                s4_a[k*16 +: 16] = am[k][15:0];
                s4_b[k*16 +: 16] = bmat[k][15:0];
            end
            s4_tb = (run < 2) ? 1'b0 : 1'($urandom);
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    s = 0;
                    for (int k = 0; k < 4; k++)
                        s += longint'(am[i*4+k]) * longint'(s4_tb ? bmat[j*4+k] : bmat[k*4+j]);
                    exp_c[(i*4+j)*35 +: 35] = s[34:0];
                end
            end
            run_op(4, bm, dm);
            if (dm !== 15'h1000) begin $display("FAIL rand4_done run %0d got %h want 1000", run, dm); n_mis++; end
            n_cmp++;
            if (s4_c !== exp_c) begin $display("FAIL rand4_c run %0d got %h want %h", run, s4_c, exp_c); n_mis++; end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_scale();
        test_truncation();
        test_transpose();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random_n4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
